// File: rtl/sniffer_pkg.sv
// Shared FSM state encoding and default sizing for the weighted match controller.
package sniffer_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_HIT_W    = 64;
  localparam int DEF_WEIGHT_W = 4;
  localparam int DEF_CMP_LAT  = 4;
  localparam int DEF_PEND_W   = 3;

  typedef enum logic [3:0] {
    S_RESET,
    S_LOAD_CFG,
    S_IDLE,
    S_LOAD,
    S_COMPARE,
    S_WAIT,
    S_SCORE,
    S_STORE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/weighted_match_controller_if.sv
// MAC-side stream handshake between the packet source and the match controller.
interface weighted_match_controller_if;

  logic ready;
  logic valid;
  logic eop;
  logic error;
  logic rdreq;

  modport master (output ready, valid, eop, error, input rdreq);
  modport slave  (input ready, valid, eop, error, output rdreq);

endinterface

// File: rtl/match_scorer.sv
// Combinational sum of the weights of every channel whose match flag is set.
module match_scorer #(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic [NUM_CH-1:0]                      match,
  input  logic [NUM_CH*WEIGHT_W-1:0]             weights,
  output logic [WEIGHT_W+$clog2(NUM_CH):0]       score
);

  localparam int SCORE_W = WEIGHT_W + $clog2(NUM_CH) + 1;

  always_comb begin
    score = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (match[i]) score = score + SCORE_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

endmodule

// File: rtl/weighted_match_controller.sv
// Packet sniffer controller: loads config, scores comparator matches per packet,
// and tracks hit, stored, error and pending-packet counts.
module weighted_match_controller
  import sniffer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int HIT_W    = DEF_HIT_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int CMP_LAT  = DEF_CMP_LAT,
  parameter int PEND_W   = DEF_PEND_W
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              update_done,
  weighted_match_controller_if.slave        mac,
  input  logic [NUM_CH-1:0]                 match,
  input  logic [NUM_CH*WEIGHT_W-1:0]        weights,
  input  logic [WEIGHT_W+$clog2(NUM_CH):0]  threshold,
  output logic                              inc_addr,
  output logic                              addr,
  output logic                              clear,
  output logic [NUM_CH*HIT_W-1:0]           hits,
  output logic [31:0]                       stored_count,
  output logic [15:0]                       err_count
);

  localparam int SCORE_W = WEIGHT_W + $clog2(NUM_CH) + 1;
  localparam int WCNT_W  = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);

  state_e                         state_q, state_d;
  logic [WCNT_W-1:0]              wait_cnt_q, wait_cnt_d;
  logic [PEND_W-1:0]              pending_q, pending_d;
  logic [SCORE_W-1:0]             score_q, score_d, score_comb;
  logic [NUM_CH-1:0][HIT_W-1:0]   hits_q, hits_d;
  logic [31:0]                    stored_q, stored_d;
  logic [15:0]                    err_q, err_d;
  logic                           rdreq_q, rdreq_d;
  logic                           inc_addr_q, inc_addr_d;
  logic                           addr_q, addr_d;
  logic                           clear_q, clear_d;
  logic                           enter_score, pend_inc, pend_dec;

  match_scorer #(
    .NUM_CH   (NUM_CH),
    .WEIGHT_W (WEIGHT_W)
  ) u_scorer (
    .match   (match),
    .weights (weights),
    .score   (score_comb)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pending_d  = pending_q;
    score_d    = score_q;
    hits_d     = hits_q;
    stored_d   = stored_q;
    err_d      = err_q;

    case (state_q)
      S_RESET:    state_d = S_LOAD_CFG;
      S_LOAD_CFG: if (update_done) state_d = S_IDLE;
      S_IDLE:     if (mac.ready && mac.valid) state_d = S_LOAD;
      S_LOAD: begin
        if (pending_q != '0)  state_d = S_COMPARE;
        else if (mac.error)   state_d = S_ERROR;
      end
      S_COMPARE: begin
        if (CMP_LAT > 0) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = S_SCORE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) state_d = S_SCORE;
        else                  wait_cnt_d = wait_cnt_q - 1'b1;
      end
      S_SCORE:    state_d = (score_q >= threshold) ? S_STORE : S_IDLE;
      S_STORE:    state_d = S_IDLE;
      S_ERROR:    if (mac.eop) state_d = S_IDLE;
      default:    state_d = S_RESET;
    endcase

    // Score and hit counts capture the match flags on the SCORE entry edge
    enter_score = (state_d == S_SCORE) && (state_q != S_SCORE);
    if (enter_score) begin
      score_d = score_comb;
      for (int i = 0; i < NUM_CH; i++) begin
        if (match[i] && (hits_q[i] != '1)) hits_d[i] = hits_q[i] + 1'b1;
      end
    end

    if ((state_d == S_STORE) && (state_q != S_STORE) && (stored_q != '1))
      stored_d = stored_q + 1'b1;
    if ((state_d == S_ERROR) && (state_q != S_ERROR) && (err_q != '1))
      err_d = err_q + 1'b1;

    pend_inc = mac.eop && !mac.error;
    pend_dec = enter_score && (pending_q != '0);
    if (pend_inc && !pend_dec && (pending_q != '1)) pending_d = pending_q + 1'b1;
    else if (pend_dec && !pend_inc)                 pending_d = pending_q - 1'b1;

    addr_d     = (state_d == S_LOAD_CFG);
    rdreq_d    = (state_d == S_LOAD);
    clear_d    = (state_d == S_IDLE) || (state_d == S_SCORE);
    inc_addr_d = (state_d == S_STORE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      pending_q  <= '0;
      score_q    <= '0;
      hits_q     <= '0;
      stored_q   <= '0;
      err_q      <= '0;
      rdreq_q    <= 1'b0;
      inc_addr_q <= 1'b0;
      addr_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      score_q    <= score_d;
      hits_q     <= hits_d;
      stored_q   <= stored_d;
      err_q      <= err_d;
      rdreq_q    <= rdreq_d;
      inc_addr_q <= inc_addr_d;
      addr_q     <= addr_d;
      clear_q    <= clear_d;
    end
  end

  assign mac.rdreq    = rdreq_q;
  assign inc_addr     = inc_addr_q;
  assign addr         = addr_q;
  assign clear        = clear_q;
  assign hits         = hits_q;
  assign stored_count = stored_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_weighted_match_controller.sv
// Directed checks of the weighted match controller with CMP_LAT=4, plus a CMP_LAT=0
// copy driven in lockstep to compare COMPARE-to-SCORE latency.
module tb_weighted_match_controller;
  import sniffer_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        update_done;
  logic [3:0]  match;
  logic [15:0] weights;
  logic [6:0]  threshold;
  logic        inc_addr, addr, clear;
  logic [255:0] hits;
  logic [31:0] stored_count;
  logic [15:0] err_count;
  logic        inc_addr0, addr0, clear0;
  logic [255:0] hits0;
  logic [31:0] stored_count0;
  logic [15:0] err_count0;

  int tests  = 0;
  int failed = 0;
  int n, n0;

  weighted_match_controller_if mif ();
  weighted_match_controller_if mif0 ();

  assign mif0.ready = mif.ready;
  assign mif0.valid = mif.valid;
  assign mif0.eop   = mif.eop;
  assign mif0.error = mif.error;

  weighted_match_controller dut (
    .clk(clk), .n_rst(n_rst), .update_done(update_done), .mac(mif.slave),
    .match(match), .weights(weights), .threshold(threshold),
    .inc_addr(inc_addr), .addr(addr), .clear(clear), .hits(hits),
    .stored_count(stored_count), .err_count(err_count)
  );

  weighted_match_controller #(.CMP_LAT(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .update_done(update_done), .mac(mif0.slave),
    .match(match), .weights(weights), .threshold(threshold),
    .inc_addr(inc_addr0), .addr(addr0), .clear(clear0), .hits(hits0),
    .stored_count(stored_count0), .err_count(err_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step from COMPARE until each DUT shows clear (SCORE); bounded so a stuck FSM cannot hang
  task automatic wait_score(output int cnt, output int cnt0);
    cnt  = 0;
    cnt0 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cnt0 == 0 && clear0) cnt0 = i;
      if (clear) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic start_packet();
    mif.ready = 1'b1;
    mif.valid = 1'b1;
    tick();
    mif.ready = 1'b0;
    mif.valid = 1'b0;
  endtask

  initial begin
    n_rst       = 1'b0;
    update_done = 1'b0;
    mif.ready   = 1'b0;
    mif.valid   = 1'b0;
    mif.eop     = 1'b0;
    mif.error   = 1'b0;
    match       = 4'b0000;
    weights     = 16'h4122;
    threshold   = 7'd4;

    tick();
    tick();
    chk("rst_state",  64'(dut.state_q), 64'(S_RESET));
    chk("rst_outs",   64'({addr, clear, inc_addr, mif.rdreq}), 64'h0);
    chk("rst_cnts",   64'({stored_count, err_count}), 64'h0);
    chk("rst_hits",   64'(|hits), 64'h0);
    chk("rst_pend",   64'(dut.pending_q), 64'h0);

    n_rst = 1'b1;
    tick();
    chk("cfg_state",  64'(dut.state_q), 64'(S_LOAD_CFG));
    chk("cfg_addr",   64'(addr), 64'h1);
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    chk("idle_state", 64'(dut.state_q), 64'(S_IDLE));
    chk("idle_addr",  64'(addr), 64'h0);
    chk("idle_clear", 64'(clear), 64'h1);

    // Packet 1: channels 0,1 match, score 2+2=4 meets threshold 4
    mif.eop = 1'b1;
    tick();
    mif.eop = 1'b0;
    chk("p1_pend",    64'(dut.pending_q), 64'h1);
    start_packet();
    chk("p1_rdreq",   64'(mif.rdreq), 64'h1);
    match = 4'b0011;
    tick();
    chk("p1_cmp_outs", 64'({mif.rdreq, clear, inc_addr}), 64'h0);
    wait_score(n, n0);
    chk("lat4",       64'(n), 64'd5);
    chk("lat0",       64'(n0), 64'd1);
    chk("p1_score",   64'(dut.score_q), 64'd4);
    chk("p1_hit0",    hits[63:0], 64'd1);
    chk("p1_hit1",    hits[127:64], 64'd1);
    chk("p1_hit2",    hits[191:128], 64'd0);
    chk("p1_pend0",   64'(dut.pending_q), 64'h0);
    match = 4'b0000;
    tick();
    chk("p1_inc",     64'(inc_addr), 64'h1);
    chk("p1_stored",  64'(stored_count), 64'd1);
    tick();
    chk("p1_inc_off", 64'(inc_addr), 64'h0);
    chk("p1_idle",    64'(clear), 64'h1);
    chk("lat0_stored", 64'(stored_count0), 64'd1);

    // Packet 2: channel 2 only, score 1 below threshold
    mif.eop = 1'b1;
    tick();
    mif.eop = 1'b0;
    start_packet();
    match = 4'b0100;
    tick();
    wait_score(n, n0);
    chk("p2_lat",     64'(n), 64'd5);
    chk("p2_score",   64'(dut.score_q), 64'd1);
    chk("p2_hit2",    hits[191:128], 64'd1);
    chk("p2_hit0",    hits[63:0], 64'd1);
    match = 4'b0000;
    tick();
    chk("p2_inc",     64'(inc_addr), 64'h0);
    chk("p2_state",   64'(dut.state_q), 64'(S_IDLE));
    chk("p2_stored",  64'(stored_count), 64'd1);

    // Packet 3: error while nothing is pending
    start_packet();
    mif.error = 1'b1;
    tick();
    mif.error = 1'b0;
    chk("err_state",  64'(dut.state_q), 64'(S_ERROR));
    chk("err_count",  64'(err_count), 64'd1);
    chk("err_outs",   64'({mif.rdreq, clear, inc_addr}), 64'h0);
    tick();
    chk("err_hold",   64'(dut.state_q), 64'(S_ERROR));
    mif.eop   = 1'b1;
    mif.error = 1'b1;
    tick();
    mif.eop   = 1'b0;
    mif.error = 1'b0;
    chk("err_exit",   64'(dut.state_q), 64'(S_IDLE));
    chk("err_pend",   64'(dut.pending_q), 64'h0);
    chk("err_count2", 64'(err_count), 64'd1);

    // Nine eops with no scoring saturate the 3-bit pending counter
    mif.eop = 1'b1;
    repeat (9) tick();
    mif.eop = 1'b0;
    chk("pend_sat",   64'(dut.pending_q), 64'd7);

    // Packet 4: eop coincides with SCORE entry
    start_packet();
    tick();
    repeat (4) tick();
    chk("p4_wait",    64'(dut.state_q), 64'(S_WAIT));
    mif.eop = 1'b1;
    tick();
    mif.eop = 1'b0;
    chk("p4_state",   64'(dut.state_q), 64'(S_SCORE));
    chk("p4_pend",    64'(dut.pending_q), 64'd7);
    chk("p4_score",   64'(dut.score_q), 64'd0);
    tick();
    chk("p4_inc",     64'(inc_addr), 64'h0);

    // Packet 5: threshold 0 stores even a zero score
    threshold = 7'd0;
    start_packet();
    tick();
    wait_score(n, n0);
    chk("p5_lat",     64'(n), 64'd5);
    chk("p5_pend",    64'(dut.pending_q), 64'd6);
    tick();
    chk("p5_inc",     64'(inc_addr), 64'h1);
    chk("p5_stored",  64'(stored_count), 64'd2);
    tick();

    // Packet 6: all weights zero, threshold 4, every channel matching
    weights   = 16'h0000;
    threshold = 7'd4;
    start_packet();
    match = 4'b1111;
    tick();
    wait_score(n, n0);
    chk("p6_score",   64'(dut.score_q), 64'd0);
    chk("p6_hit3",    hits[255:192], 64'd1);
    chk("p6_hit0",    hits[63:0], 64'd2);
    chk("p6_pend",    64'(dut.pending_q), 64'd5);
    match = 4'b0000;
    tick();
    chk("p6_inc",     64'(inc_addr), 64'h0);
    chk("p6_stored",  64'(stored_count), 64'd2);

    // Reset in the middle of a packet
    weights = 16'h4122;
    start_packet();
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    chk("mid_state",  64'(dut.state_q), 64'(S_RESET));
    chk("mid_cnts",   64'({stored_count, err_count}), 64'h0);
    chk("mid_hits",   64'(|hits), 64'h0);
    chk("mid_pend",   64'(dut.pending_q), 64'h0);
    chk("mid_outs",   64'({addr, clear, inc_addr, mif.rdreq}), 64'h0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("mid_cfg",    64'(dut.state_q), 64'(S_LOAD_CFG));
    chk("mid_addr",   64'(addr), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/weighted_match_controller.md
WEIGHTED_MATCH_CONTROLLER -- requirements
Module: weighted_match_controller

Interface
REQ-001 SHALL take parameter NUM_CH, default 4, number of comparator channels.
REQ-002 SHALL take parameter HIT_W, default 64, width of each per-channel hit counter.
REQ-003 SHALL take parameter WEIGHT_W, default 4, width of each per-channel weight.
REQ-004 SHALL take parameter CMP_LAT, default 4, number of wait cycles between COMPARE and SCORE (0 legal).
REQ-005 SHALL take parameter PEND_W, default 3, width of the pending-packet counter.
REQ-006 SHALL use reset n_rst, asynchronous, active-low, and clock clk.
REQ-007 Ports:
  clk  in  1  clock
  n_rst  in  1  async active-low reset
  update_done  in  1  comparator configuration loaded
  ready  in  1  MAC ready
  valid  in  1  MAC data valid
  eop  in  1  MAC end of packet
  error  in  1  MAC error
  match  in  NUM_CH  per-channel match flags
  weights  in  NUM_CH*WEIGHT_W  per-channel weights, channel 0 in LSBs
  threshold  in  WEIGHT_W+clog2(NUM_CH)+1  score threshold
  rdreq  out  1  input FIFO read request
  inc_addr  out  1  advance capture-memory address
  addr  out  1  configuration phase flag to Avalon slave
  clear  out  1  clear comparator match flags
  hits  out  NUM_CH*HIT_W  per-channel hit counters, channel 0 in LSBs
  stored_count  out  32  packets passing threshold
  err_count  out  16  packets aborted by error

Function
REQ-008 FSM states: RESET, LOAD_CFG, IDLE, LOAD, COMPARE, WAIT, SCORE, STORE, ERROR.
REQ-009 Transitions: RESET->LOAD_CFG unconditionally; LOAD_CFG->IDLE on update_done; IDLE->LOAD on ready&valid.
REQ-010 LOAD->COMPARE when pending>0; else LOAD->ERROR when error; else stay; pending check has priority over error.
REQ-011 COMPARE->WAIT if CMP_LAT>0, else COMPARE->SCORE; WAIT lasts exactly CMP_LAT cycles via a down-counter loaded in COMPARE.
REQ-012 SCORE->STORE if score>=threshold, else SCORE->IDLE; STORE->IDLE unconditionally; ERROR->IDLE on eop.
REQ-013 All outputs SHALL be registered and decoded from next_state, so each is asserted during the cycle the FSM occupies the named state.
REQ-014 Output decode: addr=1 only in LOAD_CFG; rdreq=1 only in LOAD; clear=1 in IDLE and SCORE; inc_addr=1 only in STORE; all others 0.
REQ-015 score = unsigned sum of weights[i] for each channel i with match[i]=1, sampled on the cycle entering SCORE; width WEIGHT_W+clog2(NUM_CH)+1, no overflow possible.
REQ-016 On entering SCORE, hits[i] SHALL increment by 1 for each match[i]=1; saturate at all-ones.
REQ-017 stored_count SHALL increment on entering STORE; err_count on entering ERROR; both saturate.
REQ-018 Pending counter: +1 on any cycle with eop=1 and error=0; -1 on entering SCORE when nonzero; simultaneous +1/-1 leaves it unchanged.
REQ-019 Pending counter SHALL saturate at 2^PEND_W-1 (extra eop dropped) and never underflow below 0.
REQ-020 threshold=0 SHALL route every scored packet to STORE; all weights 0 with threshold>0 SHALL route none.

Reset
REQ-021 While n_rst=0: state=RESET, all 1-bit outputs 0, hits/stored_count/err_count/pending/wait counter 0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet with no counter update; after release the FSM SHALL re-enter LOAD_CFG.

Structure
REQ-023 State enum and default parameter constants SHALL reside in shared package sniffer_pkg.
REQ-024 Score summation SHALL be a separate combinational sub-module match_scorer (parameters NUM_CH, WEIGHT_W).

Verification
REQ-025 Reset, then update_done=1 one cycle -> addr 1 then 0, FSM IDLE, all counters 0.
REQ-026 Weights {4,1,2,2} (ch3..ch0), threshold 4, match=0b0011, eop pulsed -> score 4, hits[0]=hits[1]=1, one inc_addr pulse, stored_count=1.
REQ-027 Same weights, match=0b0100 -> score 1, no inc_addr, hits[2]=1, return to IDLE.
REQ-028 CMP_LAT=4 -> exactly 4 cycles between COMPARE exit and SCORE; CMP_LAT=0 -> COMPARE directly to SCORE.
REQ-029 In LOAD with pending=0, error=1 -> ERROR, err_count=1; stay until eop=1 -> IDLE, pending unchanged.
REQ-030 PEND_W=3, 9 eop pulses with no SCORE -> pending=7; eop coincident with SCORE entry -> pending unchanged.
